// File: rtl/uart_pkg.sv
// Shared types for the UART RAM read arbiter: FSM state and requester identity.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package uart_pkg;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    GrantIf = 2'd1,
    GrantLs = 2'd2
  } arb_state_t;

  typedef enum logic {
    ReqIf = 1'b0,
    ReqLs = 1'b1
  } req_id_t;

endpackage

// File: rtl/uart_arb2.sv
// Two-way winner select between instruction-fetch and load/store requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; UART_ARB_RR_EN selects round-robin, otherwise ls has fixed priority.
module uart_arb2
  import uart_pkg::*;
(
  output req_id_t o_winner,
  input  logic    i_req_if,
  input  logic    i_req_ls
`ifdef UART_ARB_RR_EN
  , input  req_id_t i_last
`endif
);

  // Resolve contention; a lone requester always wins.
  always_comb begin
    o_winner = ReqIf;
    if (i_req_if && i_req_ls) begin
`ifdef UART_ARB_RR_EN
      o_winner = (i_last == ReqIf) ? ReqLs : ReqIf;
`else
      o_winner = ReqLs;
`endif
    end else if (i_req_ls) begin
      o_winner = ReqLs;
    end
  end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Arbitrates IF and LS read requests onto one UART RAM read port (macro UART_ARB_RR_EN = round-robin).
// Latency: one Idle cycle to grant, then the RAM round trip; ready/err are combinational in the grant.
// Backpressure: requesters hold valid until their ready/err pulse; a grant aborts after TimeoutCycles.
module uart_mem_arbiter
  import uart_pkg::*;
#(
  parameter logic [31:0] TimeoutCycles = 32'd1000000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        if_valid_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  output logic        if_err_o,
  input  logic        ls_valid_i,
  input  logic [31:0] ls_addr_i,
  output logic [31:0] ls_data_o,
  output logic        ls_ready_o,
  output logic        ls_err_o,
  output logic        rd_valid_o,
  output logic [31:0] rd_addr_o,
  input  logic [31:0] rd_data_i,
  input  logic        rd_ready_i
);

  arb_state_t  r_state;
  logic [31:0] r_addr_q;
  logic [31:0] r_tmo_cnt;
`ifdef UART_ARB_RR_EN
  req_id_t     r_last;
`endif

  req_id_t w_winner;
  logic    w_granted;
  logic    w_timeout;

  uart_arb2 u_arb2 (
    .o_winner (w_winner),
    .i_req_if (if_valid_i),
    .i_req_ls (ls_valid_i)
`ifdef UART_ARB_RR_EN
    , .i_last (r_last)
`endif
  );

  assign w_granted = (r_state != Idle);
  assign w_timeout = w_granted && (r_tmo_cnt == (TimeoutCycles - 32'd1));

  // A RAM response in the timeout cycle still counts as a completion.
  assign rd_valid_o = w_granted && !rd_ready_i && !w_timeout;
  assign rd_addr_o  = r_addr_q;
  assign if_ready_o = (r_state == GrantIf) && rd_ready_i;
  assign ls_ready_o = (r_state == GrantLs) && rd_ready_i;
  assign if_err_o   = (r_state == GrantIf) && !rd_ready_i && w_timeout;
  assign ls_err_o   = (r_state == GrantLs) && !rd_ready_i && w_timeout;
  assign if_data_o  = rd_data_i;
  assign ls_data_o  = rd_data_i;

  // Grant FSM: latch the winner's address in Idle, run the timeout counter while granted.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= Idle;
      r_addr_q  <= 32'd0;
      r_tmo_cnt <= 32'd0;
`ifdef UART_ARB_RR_EN
      r_last    <= ReqIf;
`endif
    end else begin
      case (r_state)
        Idle: begin
          if (if_valid_i || ls_valid_i) begin
            r_tmo_cnt <= 32'd0;
`ifdef UART_ARB_RR_EN
            r_last    <= w_winner;
`endif
            if (w_winner == ReqLs) begin
              r_addr_q <= ls_addr_i;
              r_state  <= GrantLs;
            end else begin
              r_addr_q <= if_addr_i;
              r_state  <= GrantIf;
            end
          end
        end
        GrantIf, GrantLs: begin
          r_tmo_cnt <= r_tmo_cnt + 32'd1;
          if (rd_ready_i || w_timeout) begin
            r_state <= Idle;
          end
        end
        default: r_state <= Idle;
      endcase
    end
  end

endmodule

// File: doc/uart_mem_arbiter.md
UART_MEM_ARBITER -- requirements
Module: uart_mem_arbiter

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter TimeoutCycles, default 32'd1000000, SHALL give the cycles a granted read may wait before it is aborted.
REQ-003 Port clk_i, input, 1 bit: clock.
REQ-004 Port reset_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 Port if_valid_i, input, 1 bit: instruction-fetch read request, held until if_ready_o.
REQ-006 Port if_addr_i, input, 32 bits: instruction-fetch address.
REQ-007 Port if_data_o, output, 32 bits: instruction-fetch read data.
REQ-008 Port if_ready_o, output, 1 bit: one-cycle completion pulse for instruction fetch.
REQ-009 Port if_err_o, output, 1 bit: one-cycle timeout pulse for instruction fetch.
REQ-010 Ports ls_valid_i (1), ls_addr_i (32), ls_data_o (32), ls_ready_o (1) and ls_err_o (1) SHALL mirror REQ-005..009 for the load/store data port.
REQ-011 Port rd_valid_o, output, 1 bit: request to the UART RAM read port.
REQ-012 Port rd_addr_o, output, 32 bits: address to the UART RAM read port.
REQ-013 Port rd_data_i, input, 32 bits: read data from the UART RAM.
REQ-014 Port rd_ready_i, input, 1 bit: one-cycle completion pulse from the UART RAM.

Function
REQ-015 The FSM SHALL have states Idle, GrantIf and GrantLs.
REQ-016 In Idle with at least one requester valid, the block SHALL pick a winner, latch the winner's address into addr_q, clear the timeout counter and enter the matching Grant state at the next edge.
REQ-017 In Idle, rd_valid_o SHALL be 0.
REQ-018 In GrantIf or GrantLs, rd_valid_o SHALL be 1 and rd_addr_o SHALL equal addr_q, held stable for the whole grant.
REQ-019 Changes on requester address inputs during a grant SHALL have no effect.
REQ-020 When rd_ready_i is high in a Grant state, the block SHALL drive rd_valid_o low in that same cycle (combinational).
REQ-021 In that same cycle the block SHALL pulse the owner's ready output and enter Idle at the next edge.
REQ-022 The non-owner's ready output SHALL stay 0.
REQ-023 if_data_o and ls_data_o SHALL both equal rd_data_i combinationally; data is valid only while the port's ready is high.
REQ-024 Latency from grant to completion SHALL be one cycle plus the UART round trip; there SHALL be no added response latency.
REQ-025 A new grant SHALL start no earlier than the cycle after completion, so there is a minimum of one Idle cycle between transactions.
REQ-026 The timeout counter SHALL increment every cycle in a Grant state.
REQ-027 When the timeout counter reaches TimeoutCycles-1 without rd_ready_i, the block SHALL pulse the owner's err output, drop rd_valid_o and enter Idle.
REQ-028 If rd_ready_i and timeout occur in the same cycle, ready SHALL win and err SHALL stay 0.
REQ-029 rd_ready_i while in Idle (a late response) SHALL be ignored: no ready pulse and no state change.
REQ-030 A requester that drops its valid during its own grant SHALL not cancel the grant; completion still pulses its ready.

Reset
REQ-031 Asserting reset_ni low SHALL asynchronously set the state to Idle, addr_q to 0, the timeout counter to 0 and the last-winner flag to the instruction-fetch port.
REQ-032 During reset, rd_valid_o, if_ready_o, ls_ready_o, if_err_o and ls_err_o SHALL be 0, and rd_addr_o SHALL be 0.
REQ-033 Reset mid-grant SHALL abandon the transaction with no ready or err pulse.

Configuration
REQ-034 The block SHALL use the macro UART_ARB_RR_EN.
REQ-035 With UART_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the port that did not win last wins, and the last-winner flag updates on every grant.
REQ-036 Without UART_ARB_RR_EN, arbitration SHALL be fixed priority with ls winning over if, and the last-winner flag SHALL be absent.
REQ-037 A single requesting port SHALL always win in either mode.

Structure
REQ-038 The state enum (Idle, GrantIf, GrantLs) and a requester-ID typedef SHALL live in the shared package uart_pkg.
REQ-039 A sub-module uart_arb2 (two-way combinational/round-robin winner select) is natural and SHALL be used.
REQ-040 No other sub-modules SHALL be used.

Verification
REQ-041 The bench SHALL drive if_valid=1, if_addr=0x0000_0100 alone, then rd_ready pulse with rd_data=0xDEAD_BEEF: rd_addr_o=0x100 with rd_valid high until that cycle, if_ready=1 with if_data=0xDEADBEEF for one cycle, and ls_ready=0.
REQ-042 The bench SHALL drive both valid in the same cycle for three consecutive transactions: with RR, grants go ls, if, ls (reset flag=if); without RR, the grant is ls all three times.
REQ-043 The bench SHALL change if_addr from 0x100 to 0x200 mid-grant: rd_addr_o stays 0x100.
REQ-044 The bench SHALL set TimeoutCycles=16 and never return rd_ready: the owner's err pulses in the 16th grant cycle, rd_valid drops and the FSM returns to Idle; a subsequent stray rd_ready produces no ready pulse.
REQ-045 The bench SHALL assert reset_ni=0 mid-grant: all outputs 0 immediately, and after release the next request is granted normally.
REQ-046 The bench SHALL assert rd_ready and timeout in the same cycle: only ready pulses.
